mor1kx_branch_resolve_queue: RTL and testbench
==============================================

# mor1kx_branch_resolve_queue

In-order tracking queue between the gshare predictor (decode) and the branch-resolution point (execute). Each predicted conditional branch (l.bf/l.bnf) is recorded with its predicted flag and predictor index. When the true flag is known, the oldest entry is retired: the block signals a mispredict, returns the training index and outcome to the predictor, and discards wrong-path entries.

## Interface
Parameters:
- GSHARE_BITS_NUM, 10, width of predictor table index
- DEPTH, 4, queue entries; power of two, ≥2
- OPTION_OPERAND_WIDTH, 32, PC width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- push_i  in  1  decode issues a bf/bnf this cycle (op_bf|op_bnf qualified by padv_decode)
- push_op_bf_i  in  1  1 = l.bf, 0 = l.bnf
- push_pred_flag_i  in  1  predicted SR[F] from predictor
- push_idx_i  in  GSHARE_BITS_NUM  predictor index used for the prediction
- push_pc_i  in  OPTION_OPERAND_WIDTH  branch PC
- resolve_i  in  1  oldest outstanding branch resolved this cycle
- flag_i  in  1  actual SR[F] at resolution
- flush_i  in  1  pipeline flush (exception/rfe), discards all entries
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- mispredict_o  out  1  one-cycle pulse: resolved branch mispredicted
- mispredict_pc_o  out  OPTION_OPERAND_WIDTH  PC of mispredicted branch, valid with mispredict_o
- update_valid_o  out  1  one-cycle pulse: train predictor
- update_idx_o  out  GSHARE_BITS_NUM  index to train
- update_taken_o  out  1  actual branch outcome

## Operation
- Entry = {op_bf, pred_flag, idx, pc}; circular buffer, wr_ptr/rd_ptr of clog2(DEPTH) bits wrapping modulo DEPTH; count of clog2(DEPTH)+1 bits.
- Push: accepted when push_i && (!full_o || resolve_i accepted same cycle); write at wr_ptr, wr_ptr+1. Push while full without resolve: dropped, state unchanged (upstream must stall on full_o).
- Resolve (resolve_i && !empty_o): read head, rd_ptr+1.
  - taken = op_bf ? flag_i : !flag_i.
  - mispredict = pred_flag != flag_i.
  - Registers update_valid_o=1, update_idx_o=idx, update_taken_o=taken; mispredict_o=mispredict, mispredict_pc_o=pc.
  - On mispredict: all remaining entries and any same-cycle push discarded; count=0, wr_ptr=rd_ptr.
- Resolve while empty: ignored, no pulses, no pointer change.
- flush_i: count=0, pointers equalised; same-cycle push dropped; same-cycle resolve still produces its update/mispredict pulses (flush only discards storage).
- Simultaneous push+resolve, no mispredict: count unchanged.

## Timing
- Reset: count=0, pointers 0, empty_o=1, full_o=0, mispredict_o=0, update_valid_o=0, update_idx_o=0, update_taken_o=0, mispredict_pc_o=0.
- full_o/empty_o derived combinationally from registered count.
- resolve in cycle N → update_valid_o/mispredict_o high in N+1 only; payload outputs hold until next resolve.
- Pushed entry resolvable the cycle after push (no same-cycle bypass push→resolve when empty).
- rst mid-operation: entries lost, outputs return to reset values next edge; no pulse emitted.

## Structure
- Predictor state encodings and entry field widths belong in mor1kx-defines.v for sharing with the gshare predictor.
- Natural sub-module: mor1kx_brq_storage (DEPTH×entry register array, write port + async read of head); control/count logic stays in the top.

## Test plan
- Reset then push 3 entries (bf, pred 1, idx 5/6/7) → count 3, empty_o=0; resolve with flag 1 → N+1 update_valid_o=1, idx 5, taken 1, mispredict_o=0.
- Push bnf pred_flag 0, idx 0x3FF, pc 0x100; resolve flag 1 → update_taken_o=0, mispredict_o=1, mispredict_pc_o=0x100, younger entries gone, empty_o=1.
- Fill to DEPTH=4 → full_o=1; extra push dropped; push+resolve same cycle → accepted, count stays 4, order preserved (idx sequence verified on 4 resolves).
- Wrap: 10 push/resolve pairs → idx returned in order, pointers wrap, no spurious mispredict.
- flush_i with 2 entries plus concurrent push → empty_o=1 next cycle; resolve afterwards → no pulses.
- Resolve on empty → no update_valid_o, count 0; rst asserted mid-burst → all outputs at reset values next cycle.

Source files
------------

// File: rtl/mor1kx_branch_resolve_queue_pkg.sv
// rtl/mor1kx_branch_resolve_queue_pkg.sv - shared entry layout and outcome helper for the branch resolve queue
package mor1kx_branch_resolve_queue_pkg;

  // Entry layout, MSB first: {op_bf, pred_flag, idx, pc}
  localparam int unsigned BRQ_FLAG_BITS = 2;

  function automatic int unsigned brq_entry_width(input int unsigned idx_w, input int unsigned pc_w);
    return BRQ_FLAG_BITS + idx_w + pc_w;
  endfunction

  // l.bf branches when SR[F] is set, l.bnf when it is clear
  function automatic logic brq_taken(input logic op_bf, input logic flag);
    return op_bf ? flag : !flag;
  endfunction

endpackage

// File: rtl/mor1kx_brq_storage.sv
// rtl/mor1kx_brq_storage.sv - DEPTH x entry register array, one write port, async head read
module mor1kx_brq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mor1kx_branch_resolve_queue.sv
// rtl/mor1kx_branch_resolve_queue.sv - in-order queue of predicted bf/bnf branches,
// retires the oldest at resolution and returns mispredict and training info.
module mor1kx_branch_resolve_queue
  import mor1kx_branch_resolve_queue_pkg::*;
#(
  parameter int GSHARE_BITS_NUM      = 10,
  parameter int DEPTH                = 4,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_i,
  input  logic                            push_op_bf_i,
  input  logic                            push_pred_flag_i,
  input  logic [GSHARE_BITS_NUM-1:0]      push_idx_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] push_pc_i,
  input  logic                            resolve_i,
  input  logic                            flag_i,
  input  logic                            flush_i,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mispredict_pc_o,
  output logic                            update_valid_o,
  output logic [GSHARE_BITS_NUM-1:0]      update_idx_o,
  output logic                            update_taken_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = int'(brq_entry_width(GSHARE_BITS_NUM, OPTION_OPERAND_WIDTH));

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [EW-1:0]                   head;
  logic                            head_op_bf, head_pred;
  logic [GSHARE_BITS_NUM-1:0]      head_idx;
  logic [OPTION_OPERAND_WIDTH-1:0] head_pc;
  logic                            do_resolve, do_push, head_mispredict, head_taken;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  assign {head_op_bf, head_pred, head_idx, head_pc} = head;

  assign do_resolve      = resolve_i && !empty_o;
  assign head_mispredict = (head_pred != flag_i);
  assign head_taken      = brq_taken(head_op_bf, flag_i);
  // A mispredict or flush makes any same-cycle push wrong-path, so it never lands
  assign do_push = push_i && (!full_o || do_resolve) && !flush_i &&
                   !(do_resolve && head_mispredict);

  mor1kx_brq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_storage (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({push_op_bf_i, push_pred_flag_i, push_idx_i, push_pc_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_resolve) rd_ptr_d = rd_ptr_q + AW'(1);
    if (flush_i || (do_resolve && head_mispredict)) begin
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_resolve);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      update_valid_o  <= 1'b0;
      mispredict_o    <= 1'b0;
      update_idx_o    <= '0;
      update_taken_o  <= 1'b0;
      mispredict_pc_o <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      update_valid_o <= do_resolve;
      mispredict_o   <= do_resolve && head_mispredict;
      if (do_resolve) begin
        update_idx_o    <= head_idx;
        update_taken_o  <= head_taken;
        mispredict_pc_o <= head_pc;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_branch_resolve_queue.sv
// tb/tb_mor1kx_branch_resolve_queue.sv - directed scoreboard bench for the branch resolve queue
module tb_mor1kx_branch_resolve_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_i = 1'b0, push_op_bf_i = 1'b0, push_pred_flag_i = 1'b0;
  logic [9:0]  push_idx_i = '0;
  logic [31:0] push_pc_i = '0;
  logic        resolve_i = 1'b0, flag_i = 1'b0, flush_i = 1'b0;
  logic        full_o, empty_o, mispredict_o, update_valid_o, update_taken_o;
  logic [31:0] mispredict_pc_o;
  logic [9:0]  update_idx_o;

  mor1kx_branch_resolve_queue #(
    .GSHARE_BITS_NUM      (10),
    .DEPTH                (DEPTH),
    .OPTION_OPERAND_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .push_i           (push_i),
    .push_op_bf_i     (push_op_bf_i),
    .push_pred_flag_i (push_pred_flag_i),
    .push_idx_i       (push_idx_i),
    .push_pc_i        (push_pc_i),
    .resolve_i        (resolve_i),
    .flag_i           (flag_i),
    .flush_i          (flush_i),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .mispredict_o     (mispredict_o),
    .mispredict_pc_o  (mispredict_pc_o),
    .update_valid_o   (update_valid_o),
    .update_idx_o     (update_idx_o),
    .update_taken_o   (update_taken_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bf;
    logic        pred;
    logic [9:0]  idx;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        taken;
    logic        mp;
    logic [9:0]  idx;
    logic [31:0] pc;
  } exp_t;

  ent_t model_q[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic [9:0]  last_idx = '0;
  logic        last_taken = 1'b0;
  logic [31:0] last_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then sample #1 after the edge
  task automatic cyc(input logic p, input logic bf, input logic pred, input logic [9:0] idx,
                     input logic [31:0] pc, input logic r, input logic fl, input logic fsh,
                     input logic rs);
    bit   full, empty, res, mp, acc;
    ent_t h, e;
    exp_t x;
    push_i = p; push_op_bf_i = bf; push_pred_flag_i = pred; push_idx_i = idx; push_pc_i = pc;
    resolve_i = r; flag_i = fl; flush_i = fsh; rst = rs;
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    res   = r && !empty && !rs;
    mp    = 1'b0;
    if (res) begin
      h = model_q.pop_front();
      mp = (h.pred != fl);
      x.taken = h.bf ? fl : !fl;
      x.mp = mp; x.idx = h.idx; x.pc = h.pc;
      exp_q.push_back(x);
    end
    acc = p && (!full || res) && !fsh && !mp && !rs;
    if (fsh || mp || rs) model_q.delete();
    if (acc) begin
      e.bf = bf; e.pred = pred; e.idx = idx; e.pc = pc;
      model_q.push_back(e);
    end
    @(posedge clk);
    #1;
    push_i = 1'b0; resolve_i = 1'b0; flush_i = 1'b0;
    if (rs) begin
      last_idx = '0; last_taken = 1'b0; last_pc = '0;
    end
    chk("update_valid", 32'(update_valid_o), 32'(res));
    if (update_valid_o && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("update_idx", 32'(update_idx_o), 32'(x.idx));
      chk("update_taken", 32'(update_taken_o), 32'(x.taken));
      chk("mispredict", 32'(mispredict_o), 32'(x.mp));
      chk("mispredict_pc", mispredict_pc_o, x.pc);
      last_idx = x.idx; last_taken = x.taken; last_pc = x.pc;
    end else begin
      chk("mispredict_idle", 32'(mispredict_o), 32'd0);
      chk("hold_idx", 32'(update_idx_o), 32'(last_idx));
      chk("hold_taken", 32'(update_taken_o), 32'(last_taken));
      chk("hold_pc", mispredict_pc_o, last_pc);
    end
    chk("empty", 32'(empty_o), 32'(model_q.size() == 0));
    chk("full", 32'(full_o), 32'(model_q.size() == DEPTH));
  endtask

  initial begin
    // Reset
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    chk("reset_empty", 32'(empty_o), 32'd1);
    chk("reset_full", 32'(full_o), 32'd0);
    chk("reset_uv", 32'(update_valid_o), 32'd0);
    chk("reset_idx", 32'(update_idx_o), 32'd0);

    // Three correctly predicted l.bf, first resolve returns idx 5 taken
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 10'(5 + i), 32'h10 + 32'(4 * i), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0);

    // l.bnf predicted not-taken, actually flag=1: mispredict squashes younger entries
    cyc(1, 0, 0, 10'h3FF, 32'h100, 0, 0, 0, 0);
    cyc(1, 1, 1, 10'h001, 32'h104, 0, 0, 0, 0);
    cyc(1, 1, 0, 10'h002, 32'h108, 0, 0, 0, 0);
    cyc(1, 1, 1, 10'h003, 32'h10C, 1, 1, 0, 0);
    chk("mp_squash_empty", 32'(empty_o), 32'd1);

    // Fill, overflow drop, push+resolve while full, then drain in order
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 10'(10 + i), 32'h200 + 32'(4 * i), 0, 0, 0, 0);
    cyc(1, 1, 1, 10'd99, 32'h2FF, 0, 0, 0, 0);
    cyc(1, 1, 1, 10'd14, 32'h210, 1, 1, 0, 0);
    chk("full_after_swap", 32'(full_o), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 1, 0, 0);

    // Pointer wrap with mixed bf/bnf outcomes, all correctly predicted
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1'(i), 1'(i + 1), 10'(20 + i), 32'h300 + 32'(4 * i), 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1'(i + 1), 0, 0);
    end

    // Flush with two entries and a concurrent push, then resolve on empty
    cyc(1, 1, 1, 10'd40, 32'h400, 0, 0, 0, 0);
    cyc(1, 1, 1, 10'd41, 32'h404, 0, 0, 0, 0);
    cyc(1, 1, 1, 10'd42, 32'h408, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0);

    // Flush alongside a resolve still reports the resolved branch
    cyc(1, 0, 1, 10'd50, 32'h500, 0, 0, 0, 0);
    cyc(1, 1, 1, 10'd51, 32'h504, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 0);

    // Reset mid-burst
    cyc(1, 1, 1, 10'd60, 32'h600, 0, 0, 0, 0);
    cyc(1, 1, 1, 10'd61, 32'h604, 0, 0, 0, 0);
    cyc(1, 1, 0, 10'd62, 32'h608, 1, 1, 0, 1);
    rst = 1'b0;
    chk("rst_mp", 32'(mispredict_o), 32'd0);
    chk("rst_uv", 32'(update_valid_o), 32'd0);
    chk("rst_taken", 32'(update_taken_o), 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
